// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame layout: A5, LEN_LO, LEN_HI, LEN*4 data bytes (LSB first), XOR checksum.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CHK,
      ST_DONE,
      ST_ERR
   } state_e;

   localparam logic [7:0] SYNC_BYTE       = 8'hA5;
   localparam int         BYTE_CNT_W      = 2;
   localparam int         LEN_W           = 16;
   localparam int         TIMEOUT_CYC_DEF = 1000000;
   localparam int         TIMER_W_DEF     = $clog2(TIMEOUT_CYC_DEF + 1);

   function automatic int timer_width(input int timeout_cyc);
      return $clog2(timeout_cyc + 1);
   endfunction

   // The core stays in reset through a failed load so it never runs a partial image.
   function automatic logic holds_core(input state_e s);
      return (s inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK, ST_ERR});
   endfunction

   function automatic logic is_busy(input state_e s);
      return (s inside {ST_SYNC, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK});
   endfunction

   function automatic logic is_timed(input state_e s);
      return (s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK});
   endfunction

endpackage

// File: rtl/imem_loader_timer.sv
// Reloadable inter-byte idle counter; expired marks the LIMIT-th consecutive idle cycle.
module imem_loader_timer
   import imem_loader_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_CYC_DEF,
   parameter int WIDTH = TIMER_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic reload,
   output logic expired
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!enable || reload) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the idle cycles already seen, so this edge is idle cycle cnt_q+1.
   assign expired = enable && !reload && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a framed byte stream, writes little-endian words to instruction
// memory from address 0, verifies the XOR checksum and then releases the core.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH       = 2048,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_load_req,
   input  logic        i_rx_vld,
   input  logic [7:0]  i_rx_data,
   output logic        o_core_reset,
   output logic        o_imem_wren,
   output logic [31:0] o_imem_addr,
   output logic [31:0] o_imem_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam int          TIMER_W = timer_width(TIMEOUT_CYC);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   state_e                state_q,      state_d;
   logic [BYTE_CNT_W-1:0] byte_cnt_q,   byte_cnt_d;
   logic [LEN_W-1:0]      len_q,        len_d;
   logic [LEN_W-1:0]      word_idx_q,   word_idx_d;
   logic [23:0]           sr_q,         sr_d;
   logic [7:0]            chk_q,        chk_d;
   logic                  wren_q,       wren_d;
   logic [31:0]           addr_q,       addr_d;
   logic [31:0]           wdata_q,      wdata_d;
   logic                  core_reset_q, core_reset_d;
   logic                  busy_q,       busy_d;
   logic                  done_q,       done_d;
   logic                  err_q,        err_d;

   logic tmr_en;
   logic tmr_expired;

   assign tmr_en = is_timed(state_q);

   imem_loader_timer #(
      .LIMIT (TIMEOUT_CYC),
      .WIDTH (TIMER_W)
   ) u_timer (
      .clk     (i_clk),
      .reset   (i_reset),
      .enable  (tmr_en),
      .reload  (i_rx_vld),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      sr_d       = sr_q;
      chk_d      = chk_q;
      wren_d     = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            // A byte arriving together with the request belongs to no frame.
            if (i_load_req) begin
               state_d    = ST_SYNC;
               chk_d      = 8'h00;
               word_idx_d = '0;
               byte_cnt_d = '0;
            end
         end

         ST_SYNC: begin
            if (i_rx_vld && (i_rx_data == SYNC_BYTE)) begin
               state_d = ST_LEN_LO;
            end
         end

         ST_LEN_LO: begin
            if (i_rx_vld) begin
               len_d   = {8'h00, i_rx_data};
               chk_d   = chk_q ^ i_rx_data;
               state_d = ST_LEN_HI;
            end else if (tmr_expired) begin
               state_d = ST_ERR;
            end
         end

         ST_LEN_HI: begin
            if (i_rx_vld) begin
               len_d      = {i_rx_data, len_q[7:0]};
               chk_d      = chk_q ^ i_rx_data;
               byte_cnt_d = '0;
               if (32'(len_d) > DEPTH_U) begin
                  state_d = ST_ERR;
               end else if (len_d == '0) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_DATA;
               end
            end else if (tmr_expired) begin
               state_d = ST_ERR;
            end
         end

         ST_DATA: begin
            if (i_rx_vld) begin
               chk_d = chk_q ^ i_rx_data;
               if (&byte_cnt_q) begin
                  wren_d     = 1'b1;
                  addr_d     = {14'h0000, word_idx_q, 2'b00};
                  wdata_d    = {i_rx_data, sr_q};
                  word_idx_d = word_idx_q + LEN_W'(1);
                  byte_cnt_d = '0;
                  if (word_idx_q == (len_q - LEN_W'(1))) begin
                     state_d = ST_CHK;
                  end
               end else begin
                  // Bytes enter at the top so the first byte ends up in bits [7:0].
                  sr_d       = {i_rx_data, sr_q[23:8]};
                  byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
               end
            end else if (tmr_expired) begin
               state_d = ST_ERR;
            end
         end

         ST_CHK: begin
            if (i_rx_vld) begin
               state_d = (i_rx_data == chk_q) ? ST_DONE : ST_ERR;
            end else if (tmr_expired) begin
               state_d = ST_ERR;
            end
         end
      endcase

      core_reset_d = holds_core(state_d);
      busy_d       = is_busy(state_d);
      done_d       = (state_d == ST_DONE);
      err_d        = (state_d == ST_ERR);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         len_q        <= '0;
         word_idx_q   <= '0;
         sr_q         <= '0;
         chk_q        <= '0;
         wren_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         len_q        <= len_d;
         word_idx_q   <= word_idx_d;
         sr_q         <= sr_d;
         chk_q        <= chk_d;
         wren_q       <= wren_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign o_core_reset = core_reset_q;
   assign o_imem_wren  = wren_q;
   assign o_imem_addr  = addr_q;
   assign o_imem_wdata = wdata_q;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed frames against a frame-position model.
module tb_imem_loader;

   localparam int DEPTH       = 2048;
   localparam int TIMEOUT_CYC = 100;

   localparam int PH_IDLE  = 0;
   localparam int PH_HUNT  = 1;
   localparam int PH_FRAME = 2;
   localparam int PH_DONE  = 3;
   localparam int PH_ERR   = 4;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_load_req;
   logic        i_rx_vld;
   logic [7:0]  i_rx_data;
   logic        o_core_reset;
   logic        o_imem_wren;
   logic [31:0] o_imem_addr;
   logic [31:0] o_imem_wdata;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   // Model: where we are in the frame, counted in bytes after the sync byte.
   int          m_phase = PH_IDLE;
   int          m_pos   = 0;
   int          m_len   = 0;
   int          m_idle  = 0;
   logic [7:0]  m_xor   = 8'h00;
   logic [31:0] m_word  = 32'h0;
   logic        m_wren  = 1'b0;
   logic [31:0] m_addr  = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [63:0] exp_q[$];
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];

   imem_loader #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .i_clk        (clk),
      .i_reset      (i_reset),
      .i_load_req   (i_load_req),
      .i_rx_vld     (i_rx_vld),
      .i_rx_data    (i_rx_data),
      .o_core_reset (o_core_reset),
      .o_imem_wren  (o_imem_wren),
      .o_imem_addr  (o_imem_addr),
      .o_imem_wdata (o_imem_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic model_clear();
      m_phase = PH_IDLE;
      m_pos   = 0;
      m_len   = 0;
      m_idle  = 0;
      m_xor   = 8'h00;
      m_wren  = 1'b0;
      m_addr  = 32'h0;
      m_wdata = 32'h0;
      exp_q.delete();
   endtask

   task automatic model_step();
      int k;
      m_wren = 1'b0;
      case (m_phase)
         PH_IDLE, PH_DONE, PH_ERR: begin
            if (i_load_req) begin
               m_phase = PH_HUNT;
               m_xor   = 8'h00;
            end
         end
         PH_HUNT: begin
            if (i_rx_vld && i_rx_data == 8'hA5) begin
               m_phase = PH_FRAME;
               m_pos   = 0;
               m_idle  = 0;
            end
         end
         default: begin
            if (i_rx_vld) begin
               m_idle = 0;
               m_pos++;
               if (m_pos == 1) begin
                  m_len = int'(i_rx_data);
                  m_xor = m_xor ^ i_rx_data;
               end else if (m_pos == 2) begin
                  m_len = m_len + 256 * int'(i_rx_data);
                  m_xor = m_xor ^ i_rx_data;
                  if (m_len > DEPTH) m_phase = PH_ERR;
               end else if (m_pos <= 2 + 4 * m_len) begin
                  m_xor = m_xor ^ i_rx_data;
                  k = m_pos - 3;
                  m_word[8 * (k % 4) +: 8] = i_rx_data;
                  if (k % 4 == 3) begin
                     m_wren  = 1'b1;
                     m_addr  = 32'(4 * (k / 4));
                     m_wdata = m_word;
                     exp_q.push_back({m_addr, m_wdata});
                  end
               end else begin
                  m_phase = (i_rx_data == m_xor) ? PH_DONE : PH_ERR;
               end
            end else begin
               m_idle++;
               if (m_idle >= TIMEOUT_CYC) m_phase = PH_ERR;
            end
         end
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge i_reset);
         if (i_reset) model_clear();
         else model_step();
      end
   end

   task automatic compare_cycle();
      logic [63:0] w;
      chk("core_reset", 32'(o_core_reset),
          32'(m_phase == PH_HUNT || m_phase == PH_FRAME || m_phase == PH_ERR));
      chk("busy", 32'(o_busy), 32'(m_phase == PH_HUNT || m_phase == PH_FRAME));
      chk("done", 32'(o_done), 32'(m_phase == PH_DONE));
      chk("err", 32'(o_err), 32'(m_phase == PH_ERR));
      chk("imem_wren", 32'(o_imem_wren), 32'(m_wren));
      if (o_imem_wren) begin
         wr_addr_log.push_back(o_imem_addr);
         wr_data_log.push_back(o_imem_wdata);
         w = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
         chk("write_addr", o_imem_addr, w[63:32]);
         chk("write_data", o_imem_wdata, w[31:0]);
      end else begin
         chk("addr_hold", o_imem_addr, m_addr);
         chk("wdata_hold", o_imem_wdata, m_wdata);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) compare_cycle();
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic with_req, input int gap);
      @(negedge clk);
      i_rx_vld   = 1'b1;
      i_rx_data  = b;
      i_load_req = with_req;
      @(negedge clk);
      i_rx_vld   = 1'b0;
      i_load_req = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_load();
      @(negedge clk);
      i_load_req = 1'b1;
      @(negedge clk);
      i_load_req = 1'b0;
   endtask

   task automatic send_frame(input byte_q_t fr, input int max_gap, input int req_at);
      for (int i = 0; i < fr.size(); i++) begin
         send_byte(fr[i], 1'(i == req_at), int'($urandom_range(0, max_gap)));
      end
   endtask

   function automatic byte_q_t make_frame(input int len, input logic corrupt);
      byte_q_t    f;
      logic [7:0] x;
      logic [7:0] b;
      f.push_back(8'hA5);
      f.push_back(len[7:0]);
      f.push_back(len[15:8]);
      x = len[7:0] ^ len[15:8];
      for (int i = 0; i < 4 * len; i++) begin
         b = 8'($urandom);
         f.push_back(b);
         x = x ^ b;
      end
      if (corrupt) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
      return f;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_core_reset"}, 32'(o_core_reset), 32'd0);
      chk({tag, "_wren"}, 32'(o_imem_wren), 32'd0);
      chk({tag, "_addr"}, o_imem_addr, 32'd0);
      chk({tag, "_wdata"}, o_imem_wdata, 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_done"}, 32'(o_done), 32'd0);
      chk({tag, "_err"}, 32'(o_err), 32'd0);
   endtask

   initial begin
      logic [7:0] nf [12];
      byte_q_t    fq;
      int         n0;
      int         n;
      int         len;
      logic       bad;

      nf = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h6B};
      i_reset    = 1'b1;
      i_load_req = 1'b0;
      i_rx_vld   = 1'b0;
      i_rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      i_reset = 1'b0;
      chk_en  = 1'b1;
      repeat (2) @(negedge clk);

      // Normal load with the reference program.
      pulse_load();
      n0 = wr_addr_log.size();
      for (int i = 0; i < 12; i++) begin
         send_byte(nf[i], 1'b0, 0);
         if (i == 6) begin
            chk("word0_wren", 32'(o_imem_wren), 32'd1);
            chk("word0_addr", o_imem_addr, 32'h0000_0000);
            chk("word0_data", o_imem_wdata, 32'h0010_0513);
         end
         if (i == 10) begin
            chk("word1_wren", 32'(o_imem_wren), 32'd1);
            chk("word1_addr", o_imem_addr, 32'h0000_0004);
            chk("word1_data", o_imem_wdata, 32'h0000_006F);
         end
      end
      chk("normal_done", 32'(o_done), 32'd1);
      chk("normal_core_reset", 32'(o_core_reset), 32'd0);
      chk("normal_writes", 32'(wr_addr_log.size() - n0), 32'd2);

      // Same frame with a wrong checksum.
      pulse_load();
      nf[11] = 8'h6A;
      for (int i = 0; i < 12; i++) send_byte(nf[i], 1'b0, 1);
      chk("badchk_err", 32'(o_err), 32'd1);
      chk("badchk_core_reset", 32'(o_core_reset), 32'd1);
      chk("badchk_done", 32'(o_done), 32'd0);

      // Oversize length.
      pulse_load();
      n0 = wr_addr_log.size();
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h08, 1'b0, 0);
      chk("oversize_err", 32'(o_err), 32'd1);
      chk("oversize_busy", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("oversize_writes", 32'(wr_addr_log.size() - n0), 32'd0);

      // Zero length behind garbage bytes.
      pulse_load();
      n0 = wr_addr_log.size();
      fq = {8'h11, 8'h22, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_frame(fq, 1, -1);
      chk("zero_done", 32'(o_done), 32'd1);
      chk("zero_writes", 32'(wr_addr_log.size() - n0), 32'd0);

      // Silence after the low length byte.
      pulse_load();
      send_byte(8'hA5, 1'b0, 0);
      send_byte(8'h02, 1'b0, 0);
      n = 0;
      while (!o_err && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'd100);

      // Load request in the middle of DATA is ignored.
      pulse_load();
      n0 = wr_addr_log.size();
      send_frame(make_frame(3, 1'b0), 2, 5);
      chk("midreq_done", 32'(o_done), 32'd1);
      chk("midreq_writes", 32'(wr_addr_log.size() - n0), 32'd3);

      // Asynchronous reset after five data bytes.
      pulse_load();
      fq = make_frame(4, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(fq[i], 1'b0, int'($urandom_range(0, 2)));
      @(negedge clk);
      #2 i_reset = 1'b1;
      #1 chk_all_zero("async_reset");
      n0 = wr_addr_log.size();
      repeat (4) @(negedge clk);
      i_reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("after_reset_writes", 32'(wr_addr_log.size() - n0), 32'd0);

      // Request and byte together in IDLE: that byte is dropped.
      @(negedge clk);
      i_load_req = 1'b1;
      i_rx_vld   = 1'b1;
      i_rx_data  = 8'hA5;
      @(negedge clk);
      i_load_req = 1'b0;
      i_rx_vld   = 1'b0;
      n0 = wr_addr_log.size();
      send_frame(make_frame(2, 1'b0), 2, -1);
      chk("fresh_done", 32'(o_done), 32'd1);
      chk("fresh_writes", 32'(wr_addr_log.size() - n0), 32'd2);

      // Random frames.
      for (int it = 0; it < 12; it++) begin
         len = int'($urandom_range(0, 6));
         bad = ($urandom_range(0, 3) == 0);
         pulse_load();
         n0 = wr_addr_log.size();
         fq = make_frame(len, bad);
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            fq.push_front((8'($urandom) == 8'hA5) ? 8'h3C : 8'($urandom_range(0, 164)));
         end
         send_frame(fq, 3, int'($urandom_range(0, 30)));
         chk("rand_done", 32'(o_done), 32'(!bad));
         chk("rand_err", 32'(o_err), 32'(bad));
         chk("rand_writes", 32'(wr_addr_log.size() - n0), 32'(len));
      end

      repeat (3) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot/programming controller that sequences instruction-memory writes for the single-cycle RV32I core. It receives a framed byte stream from a serial receiver and holds the core in reset while loading. It assembles little-endian 32-bit words, writes them to instruction memory starting at address 0, verifies a checksum, then releases the core so it restarts from PC 0.

Parameters:
DEPTH, 2048, instruction memory depth in words (matches inst_mem N)
TIMEOUT_CYC, 1000000, maximum idle cycles between bytes while a load is active

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_load_req  in  1  single-cycle pulse that starts a load
i_rx_vld  in  1  byte-valid strobe from the receiver, 1 cycle per byte
i_rx_data  in  8  received byte, valid when i_rx_vld=1
o_core_reset  out  1  holds core (pc/regfile/lsu) in reset while high
o_imem_wren  out  1  instruction-memory write enable, 1-cycle pulse
o_imem_addr  out  32  byte address of the write, word-aligned
o_imem_wdata  out  32  write data
o_busy  out  1  load in progress
o_done  out  1  last load completed OK; level signal
o_err  out  1  last load failed; level signal

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; word index, byte counter, checksum and timer cleared. Reset mid-load aborts the load with no further writes.
- Frame: 0xA5 sync byte, LEN_LO, LEN_HI (16-bit word count), LEN*4 data bytes (LSB first per word), CHK byte. CHK = XOR of every byte after sync, covering the length bytes and all data bytes.
- States and transitions:
  - IDLE: the core runs and rx bytes are ignored. i_load_req -> SYNC.
  - SYNC: non-0xA5 bytes are discarded; 0xA5 -> LEN_LO.
  - LEN_LO -> LEN_HI. At LEN_HI: LEN>DEPTH -> ERR; LEN=0 -> CHK; otherwise -> DATA.
  - DATA: accumulate bytes into a shift register. On the 4th byte of a word, write that word. After word LEN-1 -> CHK.
  - CHK: byte equals the running XOR -> DONE; otherwise -> ERR.
  - DONE: wait for i_load_req -> SYNC.
  - ERR: wait for i_load_req -> SYNC.
- Outputs by state:
  - o_core_reset=1 in SYNC, LEN_LO, LEN_HI, DATA, CHK and ERR; 0 in IDLE and DONE.
  - o_busy=1 in SYNC through CHK.
  - o_done=1 only in DONE; o_err=1 only in ERR. Both clear on entry to SYNC.
- Write timing: o_imem_wren asserts the cycle after the byte that completes a word; it is registered and high for exactly 1 cycle. o_imem_addr = word_idx*4 with bits[1:0]=0. word_idx increments after each write and clears on entry to SYNC.
- The final word's write pulse and the CHK byte never coincide, because bytes are at least 1 cycle apart.
- o_imem_addr and o_imem_wdata hold their last values when wren=0.
- Timeout: in LEN_LO, LEN_HI, DATA or CHK, the timer counts cycles with no byte.
  - The timer reloads on any i_rx_vld.
  - Reaching TIMEOUT_CYC -> ERR.
  - SYNC has no timeout.
- i_load_req while o_busy=1 is ignored.
- i_rx_vld with i_load_req in the same cycle in IDLE: the load starts and that byte is ignored.
- Checksum arithmetic: 8-bit XOR, cleared on entry to SYNC.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (IDLE, SYNC, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR)
  - SYNC_BYTE = 8'hA5
  - byte-counter width
  - timer width $clog2(TIMEOUT_CYC+1)
- One sub-module, imem_loader_timer, implements the reloadable inter-byte timeout counter. Its ports are clk, reset, enable, reload, and expired.

Test Plan:
- Normal load: pulse load_req; send A5 02 00 13 05 10 00 6F 00 00 00 6B.
  - Expect wren pulses at addr 0 with data 00100513 and at addr 4 with data 0000006F.
  - Expect o_done=1 and o_core_reset=0 afterwards.
- Bad checksum: same frame ending in 6A -> o_err=1, o_core_reset stays 1, o_done=0.
- Oversize: A5 01 08 (LEN=2049, DEPTH=2048) -> ERR immediately after the third byte, no wren pulse.
- Zero length: A5 00 00 00 -> DONE with no wren pulse. Leading garbage bytes 11 22 before A5 are discarded.
- Timeout (TIMEOUT_CYC=100 in the bench): A5 02 then silence -> ERR exactly 100 cycles after byte 02.
- Robustness:
  - A second load_req mid-DATA is ignored and the word sequence continues.
  - An async i_reset after 5 data bytes -> all outputs 0 immediately, no further wren.
  - A fresh load then succeeds.
